// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption sequencer: one round per clock over a shared
// round datapath, with the key schedule expanded on the fly.
module aes_round_sequencer #(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round_idx
);

  // state   | meaning
  // S_IDLE  | waiting for a plaintext/key pair, in_ready high
  // S_ROUND | one cipher round per cycle, rounds 1..NR
  // S_DONE  | ciphertext held on out_data until the sink takes it
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t              r_fsm, w_fsm_n;
  logic [127:0]        r_state, r_out;
  logic [32*NK-1:0]    r_rk;
  logic [7:0]          r_rcon;
  logic [3:0]          r_round;

  logic [127:0]        w_rk_n, w_next, w_pre;
  logic [31:0]         w_rot_sub;
  logic [31:0]         w_n0, w_n1, w_n2, w_n3;
  logic                w_last;
  logic [7:0]          w_sb [16];
  logic [7:0]          w_sr [16];
  logic [7:0]          w_mc [16];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box from the field inverse (x^254, so 0 maps to 0) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign w_last = (r_round == 4'(NR));

  always_comb begin
    w_rot_sub = {sbox(r_rk[23:16]), sbox(r_rk[15:8]), sbox(r_rk[7:0]), sbox(r_rk[31:24])}
                ^ {r_rcon, 24'h000000};
    w_n0   = r_rk[127:96] ^ w_rot_sub;
    w_n1   = r_rk[95:64]  ^ w_n0;
    w_n2   = r_rk[63:32]  ^ w_n1;
    w_n3   = r_rk[31:0]   ^ w_n2;
    w_rk_n = {w_n0, w_n1, w_n2, w_n3};
  end

  // Byte k of the state is s(k%4, k/4); byte 0 sits in bits [127:120].
  always_comb begin
    w_sb  = '{default: 8'h00};
    w_sr  = '{default: 8'h00};
    w_mc  = '{default: 8'h00};
    w_pre = '0;
    for (int k = 0; k < 16; k++)
      w_sb[k] = sbox(r_state[127-8*k -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      w_mc[4*c]   = xtime(w_sr[4*c]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c+1] = w_sr[4*c] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c+2] = w_sr[4*c] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2]) ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
      w_mc[4*c+3] = xtime(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
    end
    for (int k = 0; k < 16; k++)
      w_pre[127-8*k -: 8] = w_last ? w_sr[k] : w_mc[k];
    w_next = w_pre ^ w_rk_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_n;
  end

  always_comb begin
    w_fsm_n = r_fsm;
    case (r_fsm)
      S_IDLE:  if (in_valid)  w_fsm_n = S_ROUND;
      S_ROUND: if (w_last)    w_fsm_n = S_DONE;
      S_DONE:  if (out_ready) w_fsm_n = S_IDLE;
      default:                w_fsm_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_rk    <= '0;
      r_rcon  <= 8'h00;
      r_round <= 4'd0;
      r_out   <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= in_data ^ in_key;
            r_rk    <= in_key;
            r_rcon  <= 8'h01;
            r_round <= 4'd1;
          end
        end
        S_ROUND: begin
          r_state <= w_next;
          r_rk    <= w_rk_n;
          r_rcon  <= xtime(r_rcon);
          // round_idx parks on the last round while the result waits in DONE
          if (w_last) r_out   <= w_next;
          else        r_round <= r_round + 4'd1;
        end
        S_DONE: begin
          if (out_ready) r_round <= 4'd0;
        end
        default: r_round <= 4'd0;
      endcase
    end
  end

  assign in_ready  = (r_fsm == S_IDLE);
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm != S_IDLE);
  assign out_data  = r_out;
  assign round_idx = r_round;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: FIPS-197 vectors, backpressure,
// back-to-back, mid-operation reset and random pairs against a reference model.
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round_idx;

  int total = 0;
  int bad   = 0;

  logic [127:0] sb_q [$];
  logic [7:0]   sbox_t [256];

  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Table built by walking generator 3 and its inverse together.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = sbox_t[s[4*((c+row)%4)+row]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r+k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic logic [127:0] pop_exp();
    if (sb_q.size() == 0) return 128'h0;
    return sb_q.pop_front();
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [127:0] pt, input logic [127:0] key);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = key;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end else begin
      sb_q.push_back(ref_enc(pt, key));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for the result, records latency and the round_idx walk, drains it.
  task automatic recv(output logic [127:0] got, output int lat, output bit walk_ok);
    walk_ok = (round_idx == 4'd1);
    lat = 0;
    got = 128'h0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
      if (round_idx != 4'(i + 1)) walk_ok = 1'b0;
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL recv_timeout out_valid=%b required=1", out_valid);
    end else begin
      got = out_data;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (round_idx !== 4'd0)  begin bad++; $display("FAIL reset_round_idx got=%0d want=0", round_idx); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_kat1();
    logic [127:0] got, exp;
    int lat; bit walk;
    send(PT1, K1);
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL kat1_busy busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready);
    end
    recv(got, lat, walk);
    exp = pop_exp();
    total++; if (got !== CT1) begin bad++; $display("FAIL kat1_data got=%h want=%h", got, CT1); end
    total++; if (exp !== CT1) begin bad++; $display("FAIL kat1_model got=%h want=%h", exp, CT1); end
    total++; if (lat != 10)   begin bad++; $display("FAIL kat1_latency got=%0d want=10", lat); end
    total++; if (!walk)       begin bad++; $display("FAIL kat1_round_walk got=bad want=1..10"); end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || round_idx !== 4'd0) begin
      bad++; $display("FAIL kat1_drain out_valid=%b in_ready=%b round_idx=%0d want 0/1/0",
                      out_valid, in_ready, round_idx);
    end
  endtask

  task automatic test_kat2();
    logic [127:0] got, exp;
    int lat; bit walk;
    send(PT2, K2);
    recv(got, lat, walk);
    exp = pop_exp();
    total++; if (got !== CT2) begin bad++; $display("FAIL kat2_data got=%h want=%h", got, CT2); end
    total++; if (got !== exp) begin bad++; $display("FAIL kat2_scoreboard got=%h want=%h", got, exp); end
  endtask

  task automatic test_backpressure();
    logic [127:0] hold, got, exp;
    int lat; bit walk, stable, seen, leaked;
    send(PT1, K1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_wait out_valid=0 want=1"); end
    hold = out_data;
    in_valid = 1'b1; in_data = PT2; in_key = K2;
    stable = 1'b1; leaked = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_data !== hold || out_valid !== 1'b1) stable = 1'b0;
      if (in_ready !== 1'b0) leaked = 1'b1;
    end
    exp = pop_exp();
    total++; if (!stable)     begin bad++; $display("FAIL bp_stable out_data/out_valid changed want held %h", hold); end
    total++; if (leaked)      begin bad++; $display("FAIL bp_in_ready got=1 want=0 while draining"); end
    total++; if (hold !== exp) begin bad++; $display("FAIL bp_data got=%h want=%h", hold, exp); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_reaccept in_ready=%b want=1", in_ready); end
    send(PT2, K2);
    recv(got, lat, walk);
    exp = pop_exp();
    total++; if (got !== CT2) begin bad++; $display("FAIL bp_second got=%h want=%h", got, CT2); end
    total++; if (sb_q.size() != 0 || exp !== CT2) begin
      bad++; $display("FAIL bp_queue size=%0d want=0", sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [2];
    int n_acc, n_out;
    logic [127:0] exp;
    n_acc = 0; n_out = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    in_valid = 1'b1; in_data = PT1; in_key = K1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && n_out < 2; cyc++) begin
      if (out_valid) begin
        exp = pop_exp();
        total++;
        if (out_data !== exp) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", n_out, out_data, exp); end
        n_out++;
      end
      if (in_valid && in_ready && n_acc < 2) begin
        sb_q.push_back(ref_enc(in_data, in_key));
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
      if (n_acc == 1) begin in_data = PT2; in_key = K2; end
      if (n_acc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (n_out != 2 || n_acc != 2) begin
      bad++; $display("FAIL b2b_count outs=%0d accepts=%0d want 2/2", n_out, n_acc);
    end
    // accept T, result T+10, drained at T+11, IDLE cycle, next accept T+12
    total++; if (acc_cyc[1] - acc_cyc[0] != 12) begin
      bad++; $display("FAIL b2b_interval got=%0d want=12", acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] got, exp;
    int lat; bit walk;
    send(PT1, K1);
    for (int i = 0; i < 20 && round_idx != 4'd5; i++) @(negedge clk);
    total++; if (round_idx !== 4'd5) begin bad++; $display("FAIL rst_mid_reach round_idx=%0d want=5", round_idx); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_outputs out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    total++; if (busy !== 1'b0 || round_idx !== 4'd0 || out_data !== 128'h0) begin
      bad++; $display("FAIL rst_mid_state busy=%b round_idx=%0d out_data=%h want 0/0/0", busy, round_idx, out_data);
    end
    sb_q.delete();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_hold out_valid=%b want=0", out_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    send(PT1, K1);
    recv(got, lat, walk);
    exp = pop_exp();
    total++; if (got !== CT1 || got !== exp) begin bad++; $display("FAIL rst_mid_after got=%h want=%h", got, CT1); end
  endtask

  task automatic test_random();
    logic [127:0] pt, key, got, exp;
    int lat, bad_walk, bad_lat;
    bit walk;
    bad_walk = 0; bad_lat = 0;
    for (int n = 0; n < 1000; n++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      send(pt, key);
      recv(got, lat, walk);
      exp = pop_exp();
      total++;
      if (got !== exp) begin bad++; $display("FAIL rand_data%0d got=%h want=%h", n, got, exp); end
      if (!walk) bad_walk++;
      if (lat != 10) bad_lat++;
    end
    total++; if (bad_walk != 0) begin bad++; $display("FAIL rand_round_walk bad_blocks=%0d want=0", bad_walk); end
    total++; if (bad_lat != 0)  begin bad++; $display("FAIL rand_latency bad_blocks=%0d want=0", bad_lat); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_kat1();
    test_kat2();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
